hwpe_stream_addressgen_ndim: RTL and testbench
==============================================

Name: hwpe_stream_addressgen_ndim

Overview:
- N-dimensional, parametrised successor to the 3-loop stream address generator.
- Walks up to NB_DIMS nested loops, each with its own length and signed byte stride.
- Emits one word-aligned address, byte strobe and per-dimension wrap flags per transaction on a valid/ready stream.
- Sits between the HWPE controller/register file and the TCDM load/store streamers (source or sink side).

Parameters:
NB_DIMS, 3, number of nested loop dimensions (1..8); dim 0 is innermost
AW, 32, address width in bits
DATA_WIDTH, 32, stream word width in bits; STEP = DATA_WIDTH/8 bytes, power of two >= 1
CNT, 16, width of per-dimension length and counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
test_mode_i  in  1  test mode, unused functionally
clear_i  in  1  synchronous clear/abort
start_i  in  1  pulse: latch configuration and start walk
base_addr_i  in  AW  byte base address
tot_len_i  in  32  total transactions to emit
len_i  in  NB_DIMS x CNT  per-dimension loop length
stride_i  in  NB_DIMS x AW  per-dimension signed byte stride
addr_valid_o  out  1  address valid
addr_ready_i  in  1  consumer ready
addr_o  out  AW  word-aligned address, low log2(STEP) bits zero
strb_o  out  STEP  byte strobe
misalign_o  out  1  generated byte address not STEP-aligned
dim_wrap_o  out  NB_DIMS  bit d: this transaction closes dim d (all lower dims also closing)
last_o  out  1  final transaction of the walk
busy_o  out  1  walk in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i. All outputs 0, all counters/offsets 0, FSM in IDLE.
- FSM IDLE -> RUN:
  - Taken on start_i with tot_len_i != 0.
  - Latches base, tot_len, len and stride. Inputs are ignored thereafter.
  - start_i with tot_len_i == 0: IDLE -> DONE, no address emitted.
- RUN:
  - Output register holds the current transaction.
  - On addr_valid_o & addr_ready_i, advance the counters and load the next transaction in the same edge. Throughput is 1 per cycle.
- RUN -> DONE: on the handshake of the transaction with last_o = 1.
- DONE -> IDLE: unconditionally after one cycle. done_o = 1 only in DONE.
- start_i is ignored in RUN and DONE.
- clear_i:
  - Highest priority, from any state: next cycle IDLE, all registers cleared, valid dropped, no done_o pulse.
  - clear_i coincident with start_i: clear wins.
- Latency: start_i sampled at edge t -> addr_valid_o = 1 after t with address derived from base_addr_i. Flags are aligned with the address they describe.
- Hold rule: while addr_valid_o & !addr_ready_i, addr_o, strb_o, misalign_o, dim_wrap_o and last_o stay stable.
- Counter nest:
  - Dim d advances only when dims 0..d-1 all sit at len-1.
  - On advance, counter c_d < len_d-1: c_d++ and off_d += sext(stride_d). Otherwise c_d = 0 and off_d = 0.
  - Top dim wraps to 0 as well, so the walk repeats if tot_len exceeds the product of the lengths.
- len_i[d] == 0 is treated as 1.
- Byte address = base + sum(off_d), modulo 2^AW. Negative strides are sign-extended and wrap-around is allowed.
- Output address and strobe:
  - addr_o = byte address with low log2(STEP) bits cleared.
  - strb_o = all-ones << byte address[log2(STEP)-1:0].
  - misalign_o = (those bits != 0).
  - For STEP == 1: strb_o = 1 and misalign_o = 0.
- dim_wrap_o[d] = 1 iff c_0..c_d all equal len-1 for the emitted transaction.
- Overall counter (32 b) counts handshakes. last_o = (overall == tot_len-1).
- busy_o = 1 in RUN and DONE.

Decomposition:
- hwpe_stream_package additions: addressgen_ndim_state_e {IDLE, RUN, DONE} and HWPE_STREAM_ADDRGEN_MAX_DIMS = 8.
- Sub-module hwpe_stream_addressgen_ndim_dim: one counter plus stride accumulator with carry-in/carry-out.
  - Instantiated NB_DIMS times in a generate loop.
  - Carry chain: carry_in(d) = carry_out(d-1); carry_in(0) = handshake.

Test Plan:
- 2D walk: base=0x100, len={3,2}, stride={4,0x40}, tot=6, ready=1 -> addr 0x100,0x104,0x108,0x140,0x144,0x148. dim_wrap_o[0] on 3rd/6th, dim_wrap_o[1] on 6th, last_o on 6th, done_o one cycle later.
- Backpressure: same config with ready toggled 1,0,0,1,... -> outputs stable while stalled, exactly 6 handshakes in order, no skipped or duplicated address.
- Negative stride and wrap-around: base=0x0, len={2,1,1}, stride={-4}, tot=3 -> 0x0, 0xFFFFFFFC, 0x0 (top dim wraps), last_o on 3rd.
- Misalignment, STEP=4: base=0x102, stride0=4, tot=2 -> addr_o 0x100 and 0x104, strb 4'b1100 both times, misalign_o=1.
- Zero length: start with tot=0 -> addr_valid_o never 1, done_o pulses the cycle after start, busy_o high that cycle only.
- Abort: clear_i after the 2nd handshake of scenario 1 -> valid=0 next cycle, no done_o; a fresh start re-emits from 0x100.

Source files
------------

// File: rtl/hwpe_stream_addressgen_ndim_pkg.sv
// Shared types for the N-dimensional stream address generator.
// Holds the walk FSM encoding and the supported dimension limit.
package hwpe_stream_addressgen_ndim_pkg;

    localparam int unsigned HWPE_STREAM_ADDRGEN_MAX_DIMS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addressgen_ndim_state_e;

endpackage

// File: rtl/hwpe_stream_addressgen_ndim_dim.sv
// One loop dimension: counter plus signed stride accumulator.
// Ports: clear_i/load_i reset or latch config, carry_i advances,
// carry_o ripples to the next dim, end_o flags cnt == len-1,
// off_o is this dim's byte offset.
module hwpe_stream_addressgen_ndim_dim
    import hwpe_stream_addressgen_ndim_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned CNT = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           load_i,
    input  logic [CNT-1:0] len_i,
    input  logic [AW-1:0]  stride_i,
    input  logic           carry_i,
    output logic           carry_o,
    output logic           end_o,
    output logic [AW-1:0]  off_o
);

    logic [CNT-1:0] len_q;
    logic [CNT-1:0] cnt_q;
    logic [AW-1:0]  stride_q;
    logic [AW-1:0]  off_q;
    logic [CNT-1:0] len_m1;

    // A zero length behaves as a single-iteration loop.
    assign len_m1  = (len_q == '0) ? '0 : len_q - CNT'(1);
    assign end_o   = (cnt_q == len_m1);
    assign carry_o = carry_i & end_o;
    assign off_o   = off_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q    <= '0;
            cnt_q    <= '0;
            stride_q <= '0;
            off_q    <= '0;
        end else if (clear_i) begin
            len_q    <= '0;
            cnt_q    <= '0;
            stride_q <= '0;
            off_q    <= '0;
        end else if (load_i) begin
            len_q    <= len_i;
            stride_q <= stride_i;
            cnt_q    <= '0;
            off_q    <= '0;
        end else if (carry_i) begin
            if (end_o) begin
                cnt_q <= '0;
                off_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT'(1);
                off_q <= off_q + stride_q;
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_addressgen_ndim.sv
// N-dimensional nested-loop address generator on a valid/ready stream.
// Ports: start_i/clear_i control, base/tot/len/stride config, addr_*
// stream (addr, strb, misalign, dim_wrap, last), busy_o/done_o status.
module hwpe_stream_addressgen_ndim
    import hwpe_stream_addressgen_ndim_pkg::*;
#(
    parameter int unsigned NB_DIMS    = 3,
    parameter int unsigned AW         = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT        = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         test_mode_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [AW-1:0]                base_addr_i,
    input  logic [31:0]                  tot_len_i,
    input  logic [NB_DIMS-1:0][CNT-1:0]  len_i,
    input  logic [NB_DIMS-1:0][AW-1:0]   stride_i,
    output logic                         addr_valid_o,
    input  logic                         addr_ready_i,
    output logic [AW-1:0]                addr_o,
    output logic [DATA_WIDTH/8-1:0]      strb_o,
    output logic                         misalign_o,
    output logic [NB_DIMS-1:0]           dim_wrap_o,
    output logic                         last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned STEP = DATA_WIDTH / 8;
    localparam int unsigned LS   = (STEP > 1) ? $clog2(STEP) : 1;

    addressgen_ndim_state_e state_q, state_d;

    logic [AW-1:0]               base_q;
    logic [31:0]                 tot_q;
    logic [31:0]                 cnt_q;
    logic                        run, hs, load, last;
    logic [NB_DIMS:0]            carry;
    logic [NB_DIMS-1:0]          at_end, wrap;
    logic [NB_DIMS-1:0][AW-1:0]  off;
    logic [AW-1:0]               byte_addr;
    logic                        unused_sig;

    assign unused_sig = test_mode_i ^ carry[NB_DIMS];

    assign run  = (state_q == RUN);
    assign hs   = run & addr_ready_i;
    assign load = (state_q == IDLE) & start_i;
    assign last = run & (cnt_q == tot_q - 32'd1);

    assign carry[0] = hs;

    for (genvar d = 0; d < NB_DIMS; d++) begin : g_dim
        hwpe_stream_addressgen_ndim_dim #(
            .AW  (AW),
            .CNT (CNT)
        ) i_dim (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear_i  (clear_i),
            .load_i   (load),
            .len_i    (len_i[d]),
            .stride_i (stride_i[d]),
            .carry_i  (carry[d]),
            .carry_o  (carry[d+1]),
            .end_o    (at_end[d]),
            .off_o    (off[d])
        );
    end

    // A dim wraps only when it and every inner dim sit at their end.
    always_comb begin
        wrap[0] = at_end[0];
        for (int d = 1; d < NB_DIMS; d++) begin
            wrap[d] = wrap[d-1] & at_end[d];
        end
    end

    always_comb begin
        byte_addr = base_q;
        for (int d = 0; d < NB_DIMS; d++) begin
            byte_addr = byte_addr + off[d];
        end
    end

    assign addr_valid_o = run;
    assign addr_o       = run ? (byte_addr & ~AW'(STEP - 1)) : '0;
    assign dim_wrap_o   = run ? wrap : '0;
    assign last_o       = last;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

    if (STEP == 1) begin : g_step1
        assign strb_o     = {STEP{run}};
        assign misalign_o = 1'b0;
    end else begin : g_stepn
        logic [LS-1:0] boff;
        assign boff       = byte_addr[LS-1:0];
        assign strb_o     = run ? ({STEP{1'b1}} << boff) : '0;
        assign misalign_o = run & (boff != '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = (tot_len_i != '0) ? RUN : DONE;
            RUN:  if (hs && last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            tot_q   <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            tot_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                base_q <= base_addr_i;
                tot_q  <= tot_len_i;
                cnt_q  <= '0;
            end else if (hs) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_addressgen_ndim.sv
// Scoreboard bench for the N-dim address generator.
// Directed walks, backpressure, wrap-around, misalign, zero length, abort.
module tb_hwpe_stream_addressgen_ndim;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              test_mode_i;
    logic              clear_i;
    logic              start_i;
    logic [31:0]       base_addr_i;
    logic [31:0]       tot_len_i;
    logic [2:0][15:0]  len_i;
    logic [2:0][31:0]  stride_i;
    logic              addr_valid_o;
    logic              addr_ready_i;
    logic [31:0]       addr_o;
    logic [3:0]        strb_o;
    logic              misalign_o;
    logic [2:0]        dim_wrap_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        mis;
        logic [2:0]  wrap;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    bit   hold_pend = 0;
    bit   last_pend = 0;
    exp_t held;

    always #5 clk = ~clk;

    hwpe_stream_addressgen_ndim #(
        .NB_DIMS(3), .AW(32), .DATA_WIDTH(32), .CNT(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .test_mode_i  (test_mode_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .tot_len_i    (tot_len_i),
        .len_i        (len_i),
        .stride_i     (stride_i),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .addr_o       (addr_o),
        .strb_o       (strb_o),
        .misalign_o   (misalign_o),
        .dim_wrap_o   (dim_wrap_o),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s,
                        input logic m, input logic [2:0] w, input logic l);
        exp_t e;
        e.addr = a; e.strb = s; e.mis = m; e.wrap = w; e.last = l;
        sb.push_back(e);
    endtask

    // Monitor: pops expected beats on handshakes, checks hold and done.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (rst_ni) begin
            act.addr = addr_o; act.strb = strb_o; act.mis = misalign_o;
            act.wrap = dim_wrap_o; act.last = last_o;
            if (hold_pend)
                check(addr_valid_o && act == held, "hold",
                      64'(act), 64'(held));
            if (last_pend)
                check(done_o, "done_after_last", 64'(done_o), 64'd1);
            hold_pend = addr_valid_o && !addr_ready_i && !clear_i;
            held = act;
            last_pend = 0;
            if (addr_valid_o && addr_ready_i) begin
                if (sb.size() == 0) begin
                    check(0, "unexpected_beat", 64'(act), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check(act == e, "beat", 64'(act), 64'(e));
                end
                last_pend = last_o;
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic start_walk(input logic [31:0] base, input logic [31:0] tot,
                              input logic [15:0] l0, input logic [15:0] l1,
                              input logic [15:0] l2, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [31:0] s2);
        @(posedge clk); #1;
        base_addr_i = base; tot_len_i = tot;
        len_i[0] = l0; len_i[1] = l1; len_i[2] = l2;
        stride_i[0] = s0; stride_i[1] = s1; stride_i[2] = s2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        base_addr_i = 32'hDEAD_BEE0; tot_len_i = 32'd99;
    endtask

    task automatic wait_done(input bit bp, input string name);
        int  k = 0;
        bit  got = 0;
        int  d0 = done_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) begin got = 1; break; end
            @(posedge clk); #1;
            if (bp) begin k++; addr_ready_i = (k % 3 == 0); end
        end
        check(got, {name, "_timeout"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        addr_ready_i = 1'b1;
        @(negedge clk);
        check(!done_o && !busy_o, {name, "_idle_after"},
              64'({done_o, busy_o}), 64'd0);
        check(sb.size() == 0, {name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check(done_cnt - d0 == 1, {name, "_one_done"},
              64'(done_cnt - d0), 64'd1);
    endtask

    task automatic push_2d();
        push(32'h100, 4'hF, 0, 3'b000, 0);
        push(32'h104, 4'hF, 0, 3'b000, 0);
        push(32'h108, 4'hF, 0, 3'b001, 0);
        push(32'h140, 4'hF, 0, 3'b000, 0);
        push(32'h144, 4'hF, 0, 3'b000, 0);
        push(32'h148, 4'hF, 0, 3'b111, 1);
    endtask

    initial begin
        int d0;
        rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        base_addr_i = '0; tot_len_i = '0; len_i = '0; stride_i = '0;
        addr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check(!addr_valid_o, "rst_valid", 64'(addr_valid_o), 64'd0);
        check(!busy_o && !done_o, "rst_status",
              64'({busy_o, done_o}), 64'd0);
        check(addr_o == '0 && strb_o == '0, "rst_addr",
              64'({addr_o, strb_o}), 64'd0);
        check(dim_wrap_o == '0 && !last_o && !misalign_o, "rst_flags",
              64'({dim_wrap_o, last_o, misalign_o}), 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        addr_ready_i = 1'b1;

        // 2D walk, len2 = 0 behaves as 1
        push_2d();
        start_walk(32'h100, 32'd6, 16'd3, 16'd2, 16'd0,
                   32'd4, 32'h40, 32'd0);
        wait_done(0, "walk2d");

        // same walk under backpressure
        push_2d();
        start_walk(32'h100, 32'd6, 16'd3, 16'd2, 16'd0,
                   32'd4, 32'h40, 32'd0);
        wait_done(1, "bp");

        // negative stride, wrap-around, top dim repeats
        push(32'h0,        4'hF, 0, 3'b000, 0);
        push(32'hFFFF_FFFC, 4'hF, 0, 3'b111, 0);
        push(32'h0,        4'hF, 0, 3'b000, 1);
        start_walk(32'h0, 32'd3, 16'd2, 16'd1, 16'd1,
                   32'hFFFF_FFFC, 32'd0, 32'd0);
        wait_done(0, "negstride");

        // misaligned base
        push(32'h100, 4'b1100, 1, 3'b000, 0);
        push(32'h104, 4'b1100, 1, 3'b111, 1);
        start_walk(32'h102, 32'd2, 16'd2, 16'd1, 16'd1,
                   32'd4, 32'd0, 32'd0);
        wait_done(0, "misalign");

        // zero total length
        d0 = done_cnt;
        start_walk(32'h200, 32'd0, 16'd3, 16'd2, 16'd1,
                   32'd4, 32'h40, 32'd0);
        @(negedge clk);
        check(done_o && busy_o && !addr_valid_o, "zero_done",
              64'({done_o, busy_o, addr_valid_o}), 64'b110);
        @(negedge clk);
        check(!done_o && !busy_o, "zero_idle",
              64'({done_o, busy_o}), 64'd0);
        check(done_cnt - d0 == 1, "zero_one_done",
              64'(done_cnt - d0), 64'd1);

        // abort after the 2nd handshake
        d0 = done_cnt;
        push(32'h100, 4'hF, 0, 3'b000, 0);
        push(32'h104, 4'hF, 0, 3'b000, 0);
        start_walk(32'h100, 32'd6, 16'd3, 16'd2, 16'd0,
                   32'd4, 32'h40, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        addr_ready_i = 1'b0;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        check(!addr_valid_o && !busy_o && !done_o, "abort_idle",
              64'({addr_valid_o, busy_o, done_o}), 64'd0);
        check(sb.size() == 0, "abort_sb", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        check(done_cnt == d0, "abort_no_done", 64'(done_cnt), 64'(d0));
        @(posedge clk); #1;
        addr_ready_i = 1'b1;
        push_2d();
        start_walk(32'h100, 32'd6, 16'd3, 16'd2, 16'd0,
                   32'd4, 32'h40, 32'd0);
        wait_done(0, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
